// File: rtl/uart_frame_pkg.sv
// Shared types and elaboration helpers for the framed UART transmitter.
// The PARITY state exists only when UART_FRAME_TX_PARITY_EN is defined.
package uart_frame_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef UART_FRAME_TX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP
    } state_e;

    function automatic int clk_div_calc(input int clk_fre, input int bps);
        return clk_fre / bps;
    endfunction

    function automatic int lw_calc(input int max_bytes);
        return $clog2(max_bytes + 1);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: counts 0..CLK_DIV-1 while enabled and flags the last cycle of each bit.
module uart_baud_tick #(
    parameter int CLK_DIV = 434
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic restart_i,
    input  logic en_i,
    output logic tick_o
);

    localparam int CW = $clog2(CLK_DIV);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          at_end;

    assign at_end = (cnt_q == CW'(CLK_DIV - 1));
    assign tick_o = en_i && at_end;

    always_comb begin
        cnt_d = cnt_q;
        if (restart_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = at_end ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_frame_tx.sv
// Multi-byte UART frame transmitter: start, 8 data bits LSB first, optional parity, stop bits.
// Define UART_FRAME_TX_PARITY_EN to insert a parity bit after the data bits.
module uart_frame_tx
    import uart_frame_pkg::*;
#(
    parameter int MAX_BYTES  = 8,
    parameter int BPS        = 115200,
    parameter int CLK_FRE    = 50_000_000,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                                   sys_clk,
    input  logic                                   sys_rst,
    input  logic [MAX_BYTES*8-1:0]                 tx_data,
    input  logic [lw_calc(MAX_BYTES)-1:0]          tx_len,
    input  logic                                   tx_msb_first,
    input  logic                                   tx_valid,
    output logic                                   tx_ready,
    output logic                                   tx_busy,
    output logic                                   tx_done,
    output logic                                   uart_txd
);

    localparam int CLK_DIV = clk_div_calc(CLK_FRE, BPS);
    localparam int LW      = lw_calc(MAX_BYTES);

    if (CLK_DIV < 2) begin : g_bad_clk_div
        $error("uart_frame_tx: CLK_FRE/BPS must be at least 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_frame_tx: STOP_BITS must be 1 or 2");
    end
    if (MAX_BYTES < 1 || MAX_BYTES > 256) begin : g_bad_max_bytes
        $error("uart_frame_tx: MAX_BYTES must be in 1..256");
    end
    if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity_odd
        $error("uart_frame_tx: PARITY_ODD must be 0 or 1");
    end

    state_e                 state_q, state_d;
    logic [MAX_BYTES*8-1:0] data_q;
    logic [LW-1:0]          len_q;
    logic                   msb_q;
    logic [LW-1:0]          byte_cnt_q, byte_cnt_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic                   stop_cnt_q, stop_cnt_d;
    logic                   done_q, done_d;
    logic                   accept;
    logic                   tick;
    logic [LW-1:0]          len_clamped;
    logic [LW-1:0]          byte_idx;
    logic [7:0]             cur_byte;
    logic                   last_byte;

    uart_baud_tick #(.CLK_DIV(CLK_DIV)) u_baud (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .restart_i (accept),
        .en_i      (state_q != ST_IDLE),
        .tick_o    (tick)
    );

    assign len_clamped = (tx_len > LW'(MAX_BYTES)) ? LW'(MAX_BYTES) : tx_len;
    assign byte_idx    = msb_q ? (len_q - LW'(1) - byte_cnt_q) : byte_cnt_q;
    assign last_byte   = (byte_cnt_q == len_q - LW'(1));

    always_comb begin
        cur_byte = 8'h00;
        for (int i = 0; i < MAX_BYTES; i++) begin
            if (byte_idx == LW'(i)) cur_byte = data_q[8*i +: 8];
        end
    end

    always_comb begin
        uart_txd = 1'b1;
        case (state_q)
            ST_START:  uart_txd = 1'b0;
            ST_DATA:   uart_txd = cur_byte[bit_cnt_q];
`ifdef UART_FRAME_TX_PARITY_EN
            ST_PARITY: uart_txd = (^cur_byte) ^ (PARITY_ODD != 0);
`endif
            default:   uart_txd = 1'b1;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        done_d     = 1'b0;
        accept     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (tx_valid) begin
                    accept     = 1'b1;
                    byte_cnt_d = '0;
                    bit_cnt_d  = '0;
                    stop_cnt_d = 1'b0;
                    // An empty frame completes immediately without touching the line.
                    if (len_clamped == '0) done_d = 1'b1;
                    else                   state_d = ST_START;
                end
            end
            ST_START: begin
                if (tick) state_d = ST_DATA;
            end
            ST_DATA: begin
                if (tick) begin
                    if (bit_cnt_q == 3'd7) begin
                        bit_cnt_d = '0;
`ifdef UART_FRAME_TX_PARITY_EN
                        state_d   = ST_PARITY;
`else
                        state_d   = ST_STOP;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
`ifdef UART_FRAME_TX_PARITY_EN
            ST_PARITY: begin
                if (tick) state_d = ST_STOP;
            end
`endif
            ST_STOP: begin
                if (tick) begin
                    if (stop_cnt_q == 1'(STOP_BITS - 1)) begin
                        stop_cnt_d = 1'b0;
                        if (last_byte) begin
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                        end else begin
                            byte_cnt_d = byte_cnt_q + LW'(1);
                            state_d    = ST_START;
                        end
                    end else begin
                        stop_cnt_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q    <= ST_IDLE;
            data_q     <= '0;
            len_q      <= '0;
            msb_q      <= 1'b0;
            byte_cnt_q <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            done_q     <= done_d;
            if (accept) begin
                data_q <= tx_data;
                len_q  <= len_clamped;
                msb_q  <= tx_msb_first;
            end
        end
    end

    assign tx_ready = (state_q == ST_IDLE);
    assign tx_busy  = ~tx_ready;
    assign tx_done  = done_q;

endmodule

// File: doc/uart_frame_tx.md
UART_FRAME_TX -- requirements
Module: uart_frame_tx

Interface
REQ-001 Parameter MAX_BYTES, default 8: maximum bytes per frame; legal range 1..256.
REQ-002 Parameter BPS, default 115200: baud rate.
REQ-003 Parameter CLK_FRE, default 50_000_000: clock frequency in Hz.
REQ-004 Parameter STOP_BITS, default 1: number of stop bits; legal values 1 or 2.
REQ-005 Parameter PARITY_ODD, default 0: 0 selects even parity, 1 selects odd; used only under UART_FRAME_TX_PARITY_EN.
REQ-006 sys_clk  in  1  sole clock; all logic on the rising edge.
REQ-007 sys_rst  in  1  synchronous, active-high reset.
REQ-008 tx_data  in  MAX_BYTES*8  frame payload; byte i is bits [8i+7:8i]; sampled on accept.
REQ-009 tx_len  in  LW  number of bytes to send, where LW = $clog2(MAX_BYTES+1); sampled on accept.
REQ-010 tx_msb_first  in  1  byte order: 0 sends byte 0 first, 1 sends byte tx_len-1 first; sampled on accept.
REQ-011 tx_valid  in  1  request; a frame is accepted on a cycle where tx_valid and tx_ready are both high.
REQ-012 tx_ready  out  1  high when a new frame can be accepted.
REQ-013 tx_busy  out  1  high while a frame is in progress.
REQ-014 tx_done  out  1  one-cycle pulse at the end of each frame.
REQ-015 uart_txd  out  1  serial line; idles high.

Function
REQ-016 The bit period SHALL be CLK_DIV = CLK_FRE/BPS cycles (integer division); elaboration SHALL fail if CLK_DIV < 2.
REQ-017 FSM states SHALL be IDLE, START, DATA, PARITY, STOP; tx_ready is high only in IDLE.
REQ-018 On accept, the block SHALL register payload, length and order; later changes to the inputs have no effect on the frame in progress.
REQ-019 uart_txd SHALL go low in the first cycle after the accept edge.
REQ-020 Each byte SHALL be framed as: start (0), 8 data bits LSB first, optional parity bit, STOP_BITS stop bits (1); each bit lasts exactly CLK_DIV cycles.
REQ-021 Consecutive bytes within a frame SHALL have zero idle gap; the next start bit follows the last stop-bit cycle directly.
REQ-022 tx_len values above MAX_BYTES SHALL be clamped to MAX_BYTES.
REQ-023 A tx_len of 0 SHALL be accepted and SHALL pulse tx_done in the next cycle; uart_txd is never driven low for it.
REQ-024 tx_done SHALL pulse in the cycle after the last stop-bit cycle; the FSM is in IDLE in that cycle, so tx_ready is also high.
REQ-025 Back-to-back: an accept in the tx_done cycle SHALL start the next start bit in the following cycle.
REQ-026 Frame duration from the accept edge to tx_done SHALL be len*(9+P+STOP_BITS)*CLK_DIV+1 cycles, where P is 1 with parity enabled and 0 otherwise.
REQ-027 tx_busy SHALL equal the inverse of tx_ready.

Reset
REQ-028 On reset: uart_txd=1, tx_ready=1, tx_busy=0, tx_done=0, FSM=IDLE, all counters cleared.
REQ-029 Reset mid-frame SHALL abort the frame without a tx_done pulse; uart_txd is high in the cycle after the reset edge.

Configuration
REQ-030 With macro UART_FRAME_TX_PARITY_EN defined: a PARITY state is inserted after DATA; the parity bit is the XOR of the 8 data bits, inverted when PARITY_ODD=1.
REQ-031 Without UART_FRAME_TX_PARITY_EN: there is no PARITY state or logic, and P=0.

Structure
REQ-032 Package uart_frame_pkg SHALL hold the FSM state enum, the CLK_DIV calculation function and the LW width function.
REQ-033 Sub-module uart_baud_tick SHALL count 0..CLK_DIV-1 and emit a bit-end tick; it is restarted on accept.
REQ-034 The byte counter and bit counter SHALL reside in uart_frame_tx.

Verification
All scenarios use CLK_FRE=1_000_000, BPS=100_000 (CLK_DIV=10), MAX_BYTES=4, STOP_BITS=1.
REQ-035 len=2, data=32'h0000_1234, msb_first=0 -> line carries 0x34 then 0x12; txd low at cycle +1; tx_done at cycle +201.
REQ-036 Same payload with msb_first=1 -> line carries 0x12 then 0x34; timing identical to REQ-035.
REQ-037 tx_valid held high through two frames -> second start bit in the cycle after tx_done; no extra idle cycles.
REQ-038 len=0 -> tx_done at +1 and txd stays high; len=7 -> 4 bytes sent, tx_done at +401.
REQ-039 sys_rst asserted during byte 1 data bits -> txd=1 and tx_ready=1 in the next cycle; no tx_done pulse.
REQ-040 UART_FRAME_TX_PARITY_EN defined, byte 0x07: PARITY_ODD=0 gives parity bit 1; PARITY_ODD=1 gives 0; len=1 frame gives tx_done at +111.
